// File: rtl/imm_gen_pipe_pkg.sv
// Shared types and opcode constants for the pipelined RISC-V immediate generator.
package imm_gen_pipe_pkg;

  typedef enum logic [2:0] {R, I, SHAMT, S, B, U, J, NONE} imm_fmt_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  // SLLI/SRLI/SRAI share funct3 001/101 and carry a shift amount, not an offset
  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word -> {imm, fmt, illegal}.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_t        o_fmt,
  output logic            o_illegal
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] raw;

  assign op = i_instr[6:0];
  assign f3 = i_instr[14:12];

  // raw is built already sign-extended to 32 bits; shift amounts are positive
  always_comb begin
    raw       = '0;
    o_fmt     = NONE;
    o_illegal = 1'b0;
    case (op)
      OP_LOAD, OP_JALR: begin
        raw   = {{20{i_instr[31]}}, i_instr[31:20]};
        o_fmt = I;
      end
      OP_IMM: begin
        if (is_shift(f3)) begin
          raw   = (XLEN == 64) ? {26'b0, i_instr[25:20]} : {27'b0, i_instr[24:20]};
          o_fmt = SHAMT;
        end else begin
          raw   = {{20{i_instr[31]}}, i_instr[31:20]};
          o_fmt = I;
        end
      end
      OP_IMM_32: begin
        if (XLEN == 32) begin
          o_illegal = 1'b1;
        end else if (is_shift(f3)) begin
          raw   = {27'b0, i_instr[24:20]};
          o_fmt = SHAMT;
        end else begin
          raw   = {{20{i_instr[31]}}, i_instr[31:20]};
          o_fmt = I;
        end
      end
      OP_STORE: begin
        raw   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        o_fmt = S;
      end
      OP_BRANCH: begin
        raw   = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        o_fmt = B;
      end
      LUI, AUIPC: begin
        raw   = {i_instr[31:12], 12'b0};
        o_fmt = U;
      end
      OP_JAL: begin
        raw   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        o_fmt = J;
      end
      OP_OP, OP_32: o_fmt = R;
      default:      o_illegal = 1'b1;
    endcase
    o_imm = XLEN'($signed(raw));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry skid buffer (main M + skid S).
// Optional statistics counters are enabled by defining IMM_GEN_STATS_EN.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_fmt,
  output logic             o_illegal,
  output logic [31:0]      o_instr,
  output logic [CNT_W-1:0] o_cnt_out,
  output logic [CNT_W-1:0] o_cnt_ill
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_t        dec_fmt;
  logic            dec_ill;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .i_instr   (i_instr),
    .o_imm     (dec_imm),
    .o_fmt     (dec_fmt),
    .o_illegal (dec_ill)
  );

  pipe_state_t     state_q, state_d;
  logic [XLEN-1:0] m_imm_q, s_imm_q;
  imm_fmt_t        m_fmt_q, s_fmt_q;
  logic            m_ill_q, s_ill_q;
  logic [31:0]     m_instr_q, s_instr_q;
  logic            acc, drn, ld_m, ld_s, mv_s;

  // ready depends on registered state only, so i_ready never reaches o_ready
  assign o_ready = (state_q != FULL);
  assign o_valid = (state_q != EMPTY);
  assign acc     = i_valid && o_ready;
  assign drn     = o_valid && i_ready;

  always_comb begin
    state_d = state_q;
    ld_m    = 1'b0;
    ld_s    = 1'b0;
    mv_s    = 1'b0;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (acc) begin
          ld_m    = 1'b1;
          state_d = ONE;
        end
        ONE: begin
          if (acc && drn) begin
            ld_m = 1'b1;
          end else if (acc) begin
            ld_s    = 1'b1;
            state_d = FULL;
          end else if (drn) begin
            state_d = EMPTY;
          end
        end
        FULL: if (drn) begin
          mv_s    = 1'b1;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      m_imm_q   <= '0;
      m_fmt_q   <= NONE;
      m_ill_q   <= 1'b0;
      m_instr_q <= '0;
      s_imm_q   <= '0;
      s_fmt_q   <= NONE;
      s_ill_q   <= 1'b0;
      s_instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (ld_m) begin
        m_imm_q   <= dec_imm;
        m_fmt_q   <= dec_fmt;
        m_ill_q   <= dec_ill;
        m_instr_q <= i_instr;
      end else if (mv_s) begin
        m_imm_q   <= s_imm_q;
        m_fmt_q   <= s_fmt_q;
        m_ill_q   <= s_ill_q;
        m_instr_q <= s_instr_q;
      end
      if (ld_s) begin
        s_imm_q   <= dec_imm;
        s_fmt_q   <= dec_fmt;
        s_ill_q   <= dec_ill;
        s_instr_q <= i_instr;
      end
    end
  end

  assign o_imm     = m_imm_q;
  assign o_fmt     = m_fmt_q;
  assign o_illegal = m_ill_q;
  assign o_instr   = m_instr_q;

`ifdef IMM_GEN_STATS_EN
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d, cnt_ill_q, cnt_ill_d;

  // saturating; flush leaves the counts alone, only rst clears them
  always_comb begin
    cnt_out_d = cnt_out_q;
    cnt_ill_d = cnt_ill_q;
    if (drn && !(&cnt_out_q))            cnt_out_d = cnt_out_q + 1'b1;
    if (drn && m_ill_q && !(&cnt_ill_q)) cnt_ill_d = cnt_ill_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_out_q <= '0;
      cnt_ill_q <= '0;
    end else begin
      cnt_out_q <= cnt_out_d;
      cnt_ill_q <= cnt_ill_d;
    end
  end

  assign o_cnt_out = cnt_out_q;
  assign o_cnt_ill = cnt_ill_q;
`else
  assign o_cnt_out = '0;
  assign o_cnt_ill = '0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: FIFO scoreboard plus a decode model, XLEN=64 and XLEN=32 instances.
module tb_imm_gen_pipe;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_SH = 3'd2, F_S = 3'd3,
                         F_B = 3'd4, F_U = 3'd5, F_J = 3'd6, F_NONE = 3'd7;

  logic        clk = 1'b0;
  logic        rst, i_flush, i_valid, i_ready;
  logic [31:0] i_instr;

  logic          rdy64, val64, ill64, rdy32, val32, ill32;
  logic [63:0]   imm64;
  logic [31:0]   imm32, ins64, ins32;
  logic [2:0]    fmt64, fmt32;
  logic [CW-1:0] cout64, cill64, cout32, cill32;

  imm_gen_pipe #(.XLEN(64), .CNT_W(CW)) u64 (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(rdy64),
    .i_instr(i_instr), .o_valid(val64), .i_ready(i_ready), .o_imm(imm64), .o_fmt(fmt64),
    .o_illegal(ill64), .o_instr(ins64), .o_cnt_out(cout64), .o_cnt_ill(cill64));

  imm_gen_pipe #(.XLEN(32), .CNT_W(CW)) u32 (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(rdy32),
    .i_instr(i_instr), .o_valid(val32), .i_ready(i_ready), .o_imm(imm32), .o_fmt(fmt32),
    .o_illegal(ill32), .o_instr(ins32), .o_cnt_out(cout32), .o_cnt_ill(cill32));

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;
  logic [31:0] q[$];
  int m_out = 0;
  int m_ill = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Decode rules written as arithmetic on signed fields
  function automatic void model(input logic [31:0] ins, input int xlen,
                                output logic [63:0] imm, output logic [2:0] fmt,
                                output logic ill);
    logic signed [11:0] s12;
    logic signed [19:0] s20;
    logic [2:0] f3;
    longint v;
    f3 = ins[14:12];
    v = 0; fmt = F_NONE; ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h67: begin s12 = ins[31:20]; v = longint'(s12); fmt = F_I; end
      7'h13, 7'h1B: begin
        if (ins[6:0] == 7'h1B && xlen == 32) ill = 1'b1;
        else if (f3 == 3'd1 || f3 == 3'd5) begin
          fmt = F_SH;
          v = (ins[6:0] == 7'h13 && xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
        end else begin s12 = ins[31:20]; v = longint'(s12); fmt = F_I; end
      end
      7'h23: begin s12 = {ins[31:25], ins[11:7]}; v = longint'(s12); fmt = F_S; end
      7'h63: begin s12 = {ins[31], ins[7], ins[30:25], ins[11:8]}; v = longint'(s12) * 2; fmt = F_B; end
      7'h37, 7'h17: begin s20 = ins[31:12]; v = longint'(s20) * 4096; fmt = F_U; end
      7'h6F: begin s20 = {ins[31], ins[19:12], ins[20], ins[30:21]}; v = longint'(s20) * 2; fmt = F_J; end
      7'h33, 7'h3B: fmt = F_R;
      default: ill = 1'b1;
    endcase
    imm = v;
  endfunction

  // Reference FIFO and counters, updated on the same edge as the DUT
  always @(posedge clk) begin
    logic [63:0] mi; logic [2:0] mf; logic ml;
    if (rst) begin
      q.delete(); m_out = 0; m_ill = 0;
    end else begin
      if (val64 && i_ready && q.size() != 0) begin
        model(q[0], 64, mi, mf, ml);
        if (m_out < CMAX) m_out++;
        if (ml && m_ill < CMAX) m_ill++;
        void'(q.pop_front());
      end
      if (i_flush) q.delete();
      else if (i_valid && rdy64) q.push_back(i_instr);
    end
  end

  always @(negedge clk) begin
    logic [63:0] mi; logic [2:0] mf; logic ml;
    if (!rst) begin
      chk("valid64", {63'b0, val64}, {63'b0, q.size() != 0});
      chk("ready64", {63'b0, rdy64}, {63'b0, q.size() < 2});
      chk("valid32", {63'b0, val32}, {63'b0, q.size() != 0});
      chk("ready32", {63'b0, rdy32}, {63'b0, q.size() < 2});
      if (q.size() != 0) begin
        model(q[0], 64, mi, mf, ml);
        chk("imm64", imm64, mi);
        chk("fmt64", {61'b0, fmt64}, {61'b0, mf});
        chk("ill64", {63'b0, ill64}, {63'b0, ml});
        chk("instr64", {32'b0, ins64}, {32'b0, q[0]});
        model(q[0], 32, mi, mf, ml);
        chk("imm32", {32'b0, imm32}, {32'b0, mi[31:0]});
        chk("fmt32", {61'b0, fmt32}, {61'b0, mf});
        chk("ill32", {63'b0, ill32}, {63'b0, ml});
        chk("instr32", {32'b0, ins32}, {32'b0, q[0]});
      end
`ifdef IMM_GEN_STATS_EN
      chk("cnt_out", 64'(cout64), 64'(m_out));
      chk("cnt_ill", 64'(cill64), 64'(m_ill));
`else
      chk("cnt_out", 64'(cout64), 64'd0);
      chk("cnt_ill", 64'(cill64), 64'd0);
`endif
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic r, input logic f);
    @(posedge clk); #1;
    i_valid = v; i_instr = ins; i_ready = r; i_flush = f;
  endtask

  logic [31:0] stream [7] = '{32'hFE000EE3, 32'h800002B7, 32'h03F09093, 32'h0000007F,
                              32'h0010809B, 32'h008000EF, 32'hFE112E23};
  logic [31:0] stats [5] = '{32'hFFF00093, 32'h0000007F, 32'hFE000EE3, 32'h800002B7, 32'h03F09093};

  initial begin
    logic [63:0] mi; logic [2:0] mf; logic ml;
    rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_instr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {63'b0, val64}, 64'd0);
    chk("rst_ready", {63'b0, rdy64}, 64'd1);
    chk("rst_imm", imm64, 64'd0);
    chk("rst_fmt", {61'b0, fmt64}, {61'b0, F_NONE});
    chk("rst_ill", {63'b0, ill64}, 64'd0);
    chk("rst_instr", {32'b0, ins64}, 64'd0);
    chk("rst_cnt", {60'b0, cout64, cill64}, 64'd0);

    // Pin the model against hand-decoded values
    model(32'hFFF00093, 64, mi, mf, ml); chk("pin_addi", {mi[60:0], mf}, {61'h1FFFFFFF_FFFFFFFF, F_I});
    model(32'hFE000EE3, 64, mi, mf, ml); chk("pin_beq", mi, 64'hFFFFFFFF_FFFFFFFC);
    model(32'h800002B7, 64, mi, mf, ml); chk("pin_lui", mi, 64'hFFFFFFFF_80000000);
    model(32'h03F09093, 64, mi, mf, ml); chk("pin_slli", {mi, 1'b0} | 65'(mf), 65'(126) | 65'(F_SH));
    model(32'h0000007F, 64, mi, mf, ml); chk("pin_bad", {mi[59:0], mf, ml}, {60'd0, F_NONE, 1'b1});
    model(32'h0010809B, 32, mi, mf, ml); chk("pin_addiw32", {63'b0, ml}, 64'd1);
    model(32'h008000EF, 64, mi, mf, ml); chk("pin_jal", mi, 64'd8);
    model(32'hFE112E23, 64, mi, mf, ml); chk("pin_sw", mi, 64'hFFFFFFFF_FFFFFFFC);

    // Single-cycle latency from EMPTY
    drive(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_valid", {63'b0, val64}, 64'd1);
    chk("lat_imm", imm64, 64'hFFFFFFFF_FFFFFFFF);
    chk("lat_fmt", {61'b0, fmt64}, {61'b0, F_I});

    foreach (stream[k]) drive(1'b1, stream[k], 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: A, B fill the buffer, C is held upstream
    drive(1'b1, 32'h00100093, 1'b0, 1'b0);
    drive(1'b1, 32'h00200113, 1'b0, 1'b0);
    drive(1'b1, 32'h00300193, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_ready", {63'b0, rdy64}, 64'd0);
    chk("bp_head", {32'b0, ins64}, 64'h00100093);
    drive(1'b1, 32'h00300193, 1'b0, 1'b0);
    drive(1'b1, 32'h00300193, 1'b1, 1'b0);
    drive(1'b1, 32'h00300193, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_second", {32'b0, ins64}, 64'h00200113);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_third", {32'b0, ins64}, 64'h00300193);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_empty", {63'b0, val64}, 64'd0);

    // Flush from FULL with a valid instruction in the flush cycle
    drive(1'b1, 32'h00500293, 1'b0, 1'b0);
    drive(1'b1, 32'h00600313, 1'b0, 1'b0);
    drive(1'b1, 32'h00700393, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_valid", {63'b0, val64}, 64'd0);
    chk("fl_ready", {63'b0, rdy64}, 64'd1);
    drive(1'b1, 32'h00800413, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_next", {32'b0, ins64}, 64'h00800413);

    // Statistics: 5 drains, 1 illegal, from a fresh reset
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    foreach (stats[k]) drive(1'b1, stats[k], 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
`ifdef IMM_GEN_STATS_EN
    chk("st_out", 64'(cout64), 64'd3);
    chk("st_ill", 64'(cill64), 64'd1);
`else
    chk("st_out", 64'(cout64), 64'd0);
    chk("st_ill", 64'(cill64), 64'd0);
`endif
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("st_rst", {60'b0, cout64, cill64}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
